// File: rtl/hqm_mem_pg_seq.sv
// Memory power-gating sequencer: drains traffic, isolates, and walks the
// daisy-chained memory power enable down/up with a shared timeout counter.
module hqm_mem_pg_seq #(
  parameter int unsigned ISOL_DLY = 4,
  parameter int unsigned PWR_TMO  = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pg_req,
  input  logic       mem_busy,
  input  logic       pwr_enable_b_in,
  input  logic       pg_err_clr,
  output logic       pwr_enable_b_out,
  output logic       pgcb_isol_en,
  output logic       mem_access_block,
  output logic       mem_ready,
  output logic       pg_ack,
  output logic       pg_err,
  output logic [2:0] pg_state
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] ISOL_LD = CNT_W'(ISOL_DLY);
  localparam logic [CNT_W-1:0] TMO_LD  = CNT_W'(PWR_TMO);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_ON       = 3'd0,
    ST_DRAIN    = 3'd1,
    ST_ISOL     = 3'd2,
    ST_OFF_WAIT = 3'd3,
    ST_OFF      = 3'd4,
    ST_ON_WAIT  = 3'd5,
    ST_DEISOL   = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sync_q;
  logic             pe_sync;
  logic             pe_q, pe_d;
  logic             isol_q, isol_d;
  logic             block_q, block_d;
  logic             ready_q, ready_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             tmo;

  assign pe_sync = sync_q[1];

  // Chain acknowledge synchronizer; resets to "chain off".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], pwr_enable_b_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ON_WAIT;
      cnt_q   <= TMO_LD;
      pe_q    <= 1'b0;
      isol_q  <= 1'b1;
      block_q <= 1'b1;
      ready_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pe_q    <= pe_d;
      isol_q  <= isol_d;
      block_q <= block_d;
      ready_q <= ready_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // Next state, shared counter, sticky error; outputs decoded from next state
  // so every output is a flop and tracks the state it belongs to.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo     = 1'b0;
    pe_d    = 1'b0;
    isol_d  = 1'b1;
    block_d = 1'b1;
    ready_d = 1'b0;
    ack_d   = 1'b0;

    case (state_q)
      ST_ON: begin
        if (pg_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!pg_req) begin
          state_d = ST_ON;
        end else if (!mem_busy) begin
          state_d = ST_ISOL;
          cnt_d   = ISOL_LD;
        end
      end
      ST_ISOL: begin
        if (cnt_q <= CNT_ONE) begin
          state_d = ST_OFF_WAIT;
          cnt_d   = TMO_LD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_OFF_WAIT: begin
        if (pe_sync) begin
          state_d = ST_OFF;
        end else if (cnt_q <= CNT_ONE) begin
          state_d = ST_OFF;
          tmo     = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_OFF: begin
        if (!pg_req) begin
          state_d = ST_ON_WAIT;
          cnt_d   = TMO_LD;
        end
      end
      ST_ON_WAIT: begin
        if (!pe_sync || cnt_q <= CNT_ONE) begin
          state_d = ST_DEISOL;
          cnt_d   = ISOL_LD;
          tmo     = pe_sync;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_DEISOL: begin
        if (cnt_q <= CNT_ONE) begin
          state_d = ST_ON;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_ON_WAIT;
        cnt_d   = TMO_LD;
      end
    endcase

    err_d = tmo | (err_q & ~pg_err_clr);

    case (state_d)
      ST_ON: begin
        isol_d  = 1'b0;
        block_d = 1'b0;
        ready_d = 1'b1;
      end
      ST_DRAIN:    isol_d = 1'b0;
      ST_OFF_WAIT: pe_d   = 1'b1;
      ST_OFF: begin
        pe_d  = 1'b1;
        ack_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign pwr_enable_b_out = pe_q;
  assign pgcb_isol_en     = isol_q;
  assign mem_access_block = block_q;
  assign mem_ready        = ready_q;
  assign pg_ack           = ack_q;
  assign pg_err           = err_q;
  assign pg_state         = state_q;

endmodule

// File: tb/tb_hqm_mem_pg_seq.sv
// Scoreboard bench for hqm_mem_pg_seq: expected state/err snapshots are queued
// by the stimulus and checked by a monitor on every observed change.
module tb_hqm_mem_pg_seq;

  localparam logic [2:0] S_ON = 3'd0, S_DRAIN = 3'd1, S_ISOL = 3'd2, S_OFFW = 3'd3,
                         S_OFF = 3'd4, S_ONW = 3'd5, S_DEISOL = 3'd6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pg_req = 1'b0;
  logic mem_busy = 1'b0;
  logic pg_err_clr = 1'b0;
  logic pe_in = 1'b0;
  logic pwr_enable_b_out, pgcb_isol_en, mem_access_block, mem_ready, pg_ack, pg_err;
  logic [2:0] pg_state;
  int chain_mode = 0;  // 0 echo, 1 stuck low, 2 stuck high

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [2:0] st;
    logic [5:0] outs;  // {pe, isol, block, ready, ack, err}
    int         dwell;
  } exp_t;
  exp_t sb[$];

  hqm_mem_pg_seq #(.ISOL_DLY(4), .PWR_TMO(64)) dut (
    .clk(clk), .rst_n(rst_n), .pg_req(pg_req), .mem_busy(mem_busy),
    .pwr_enable_b_in(pe_in), .pg_err_clr(pg_err_clr),
    .pwr_enable_b_out(pwr_enable_b_out), .pgcb_isol_en(pgcb_isol_en),
    .mem_access_block(mem_access_block), .mem_ready(mem_ready),
    .pg_ack(pg_ack), .pg_err(pg_err), .pg_state(pg_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    pe_in <= (chain_mode == 1) ? 1'b0 : (chain_mode == 2) ? 1'b1 : pwr_enable_b_out;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input string name, input logic [2:0] st, input logic err, input int dwell);
    exp_t e;
    logic [4:0] o;
    case (st)
      S_ON:     o = 5'b00010;
      S_DRAIN:  o = 5'b00100;
      S_ISOL:   o = 5'b01100;
      S_OFFW:   o = 5'b11100;
      S_OFF:    o = 5'b11101;
      default:  o = 5'b01100;
    endcase
    e.name = name; e.st = st; e.outs = {o, err}; e.dwell = dwell;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk({name, "_drain_timeout"}, sb.size(), 0);
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_state(input string name, input logic [2:0] st);
    int n = 0;
    while (pg_state != st && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (pg_state != st) chk({name, "_wait_timeout"}, int'(pg_state), int'(st));
  endtask

  // Monitor: compare on every change of {state, err}, plus per-cycle invariants.
  logic [3:0] prev_key = {S_ONW, 1'b0};
  int dwell_cnt = 0;
  always @(negedge clk) begin
    logic [3:0] cur;
    exp_t e;
    if (!rst_n) begin
      prev_key  = {S_ONW, 1'b0};
      dwell_cnt = 0;
    end else begin
      chk("inv_ready_ack", int'(mem_ready & pg_ack), 0);
      chk("inv_pe_isol", int'(pwr_enable_b_out & ~pgcb_isol_en), 0);
      cur = {pg_state, pg_err};
      if (cur != prev_key) begin
        if (sb.size() == 0) begin
          chk("unexpected_change", int'(cur), int'(prev_key));
        end else begin
          e = sb.pop_front();
          chk({e.name, "_state"}, int'(pg_state), int'(e.st));
          chk({e.name, "_outs"},
              int'({pwr_enable_b_out, pgcb_isol_en, mem_access_block, mem_ready, pg_ack, pg_err}),
              int'(e.outs));
          if (e.dwell >= 0) chk({e.name, "_dwell"}, dwell_cnt, e.dwell);
        end
        prev_key  = cur;
        dwell_cnt = 1;
      end else begin
        dwell_cnt++;
      end
    end
  end

  initial begin
    // Reset values while held in reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", int'(pg_state), int'(S_ONW));
    chk("rst_pe", int'(pwr_enable_b_out), 0);
    chk("rst_isol", int'(pgcb_isol_en), 1);
    chk("rst_block", int'(mem_access_block), 1);
    chk("rst_ready_ack_err", int'({mem_ready, pg_ack, pg_err}), 0);

    // Autonomous power-up
    @(negedge clk);
    rst_n = 1'b1;
    push("pu_deisol", S_DEISOL, 1'b0, -1);
    push("pu_on", S_ON, 1'b0, 4);
    wait_idle("pu");

    // Drain held 10 cycles, then full power-down and power-up
    pg_req = 1'b1; mem_busy = 1'b1;
    push("dn_drain", S_DRAIN, 1'b0, -1);
    push("dn_isol", S_ISOL, 1'b0, 10);
    push("dn_offw", S_OFFW, 1'b0, 4);
    push("dn_off", S_OFF, 1'b0, 4);
    repeat (10) @(negedge clk);
    mem_busy = 1'b0;
    wait_idle("dn");
    pg_req = 1'b0;
    push("up_onw", S_ONW, 1'b0, -1);
    push("up_deisol", S_DEISOL, 1'b0, 4);
    push("up_on", S_ON, 1'b0, 4);
    wait_idle("up");

    // Abort during drain
    pg_req = 1'b1; mem_busy = 1'b1;
    push("ab_drain", S_DRAIN, 1'b0, -1);
    push("ab_on", S_ON, 1'b0, 3);
    repeat (3) @(negedge clk);
    pg_req = 1'b0;
    wait_idle("ab");
    mem_busy = 1'b0;

    // pg_req dropped during ISOL: sequence completes, OFF for one cycle
    pg_req = 1'b1;
    push("ti_drain", S_DRAIN, 1'b0, -1);
    push("ti_isol", S_ISOL, 1'b0, 1);
    push("ti_offw", S_OFFW, 1'b0, 4);
    push("ti_off", S_OFF, 1'b0, 4);
    push("ti_onw", S_ONW, 1'b0, 1);
    push("ti_deisol", S_DEISOL, 1'b0, 4);
    push("ti_on", S_ON, 1'b0, 4);
    repeat (2) @(negedge clk);
    pg_req = 1'b0;
    wait_idle("ti");

    // Chain stuck low on power-down: timeout after 64 OFF_WAIT cycles
    chain_mode = 1;
    pg_req = 1'b1;
    push("tl_drain", S_DRAIN, 1'b0, -1);
    push("tl_isol", S_ISOL, 1'b0, 1);
    push("tl_offw", S_OFFW, 1'b0, 4);
    push("tl_off_err", S_OFF, 1'b1, 64);
    wait_idle("tl");
    pg_err_clr = 1'b1;
    push("tl_clr", S_OFF, 1'b0, -1);
    @(negedge clk);
    pg_err_clr = 1'b0;
    wait_idle("tl_clr");

    // Chain stuck high on power-up with clear held: set wins over clear
    chain_mode = 2;
    repeat (3) @(negedge clk);
    pg_err_clr = 1'b1;
    pg_req = 1'b0;
    push("th_onw", S_ONW, 1'b0, -1);
    push("th_deisol_err", S_DEISOL, 1'b1, 64);
    push("th_on_err", S_ON, 1'b1, 4);
    @(negedge clk);
    wait_state("th", S_DEISOL);
    pg_err_clr = 1'b0;
    wait_idle("th");
    pg_err_clr = 1'b1;
    push("th_clr", S_ON, 1'b0, -1);
    @(negedge clk);
    pg_err_clr = 1'b0;
    wait_idle("th_clr");
    chain_mode = 0;
    repeat (4) @(negedge clk);

    // Asynchronous reset while in OFF_WAIT
    pg_req = 1'b1;
    push("rs_drain", S_DRAIN, 1'b0, -1);
    push("rs_isol", S_ISOL, 1'b0, 1);
    push("rs_offw", S_OFFW, 1'b0, 4);
    wait_state("rs", S_OFFW);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_state", int'(pg_state), int'(S_ONW));
    chk("ar_pe", int'(pwr_enable_b_out), 0);
    chk("ar_isol_block", int'({pgcb_isol_en, mem_access_block}), 3);
    chk("ar_ready_ack_err", int'({mem_ready, pg_ack, pg_err}), 0);
    pg_req = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    push("rs_deisol", S_DEISOL, 1'b0, -1);
    push("rs_on", S_ON, 1'b0, 4);
    wait_idle("rs");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
